// File: rtl/spi_mem_responder.sv
// SPI mode-0 memory target (READ 0x03 / WRITE 0x02, 24-bit address) backed by a
// byte array, with a backdoor port for preloading and inspection.
module spi_mem_responder #(
  parameter int ADDR_W   = 8,
  parameter bit WRITE_EN = 1'b1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              sclk_in,
  input  logic              cs_n_in,
  input  logic              mosi_in,
  output logic              miso_out,
  input  logic              bd_we_in,
  input  logic [ADDR_W-1:0] bd_addr_in,
  input  logic [7:0]        bd_wdata_in,
  output logic [7:0]        bd_rdata_out,
  output logic              busy_out,
  output logic              cmd_err_out
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ_DATA, WRITE_DATA, IGNORE} state_t;

  state_t state_q, state_d;
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [2:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;
  logic [7:0] shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0] cnt_q, cnt_d;
  logic rd_q, rd_d;
  logic miso_q, miso_d;
  logic err_q, err_d;

  logic [7:0] mem [DEPTH];

  logic sclk_rise, sclk_fall, cs_fall, cs_high, mosi_s;
  logic [7:0] rx_byte, mem_rdata;
  logic [ADDR_W-1:0] addr_shift, addr_inc, rd_addr;
  logic spi_we;

  assign sclk_rise  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_fall    = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_high    = cs_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign rx_byte    = {shift_q[6:0], mosi_s};
  assign addr_shift = {addr_q[ADDR_W-2:0], mosi_s};
  assign addr_inc   = addr_q + ADDR_W'(1);
  // Look-ahead read: the address being completed in ADDR, or the next byte while streaming.
  assign rd_addr    = (state_q == ADDR) ? addr_shift : addr_inc;
  assign mem_rdata  = mem[rd_addr];

  assign bd_rdata_out = mem[bd_addr_in];
  assign busy_out     = (state_q != IDLE) && (state_q != IGNORE);
  assign cmd_err_out  = err_q;
  assign miso_out     = miso_q & ~cs_high;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk_in};
    cs_sync_d   = {cs_sync_q[1:0], cs_n_in};
    mosi_sync_d = {mosi_sync_q[0], mosi_in};
    state_d = state_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    miso_d  = miso_q;
    err_d   = err_q;
    spi_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = 5'd0;
          shift_d = 8'h00;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d = 5'd0;
            case (rx_byte)
              8'h03: begin
                state_d = ADDR;
                rd_d    = 1'b1;
              end
              8'h02: begin
                rd_d    = 1'b0;
                state_d = WRITE_EN ? ADDR : IGNORE;
              end
              default: begin
                state_d = IGNORE;
                err_d   = 1'b1;
              end
            endcase
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          addr_d = addr_shift;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_q == 5'd23) begin
            cnt_d = 5'd0;
            if (rd_q) begin
              shift_d = mem_rdata;
              state_d = READ_DATA;
            end else begin
              state_d = WRITE_DATA;
            end
          end
        end
      end
      READ_DATA: begin
        if (sclk_fall) begin
          miso_d = shift_q[7];
          cnt_d  = cnt_q + 5'd1;
          shift_d = {shift_q[6:0], 1'b0};
          if (cnt_q == 5'd7) begin
            cnt_d   = 5'd0;
            addr_d  = addr_inc;
            shift_d = mem_rdata;
          end
        end
      end
      WRITE_DATA: begin
        if (sclk_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            cnt_d  = 5'd0;
            spi_we = 1'b1;
            addr_d = addr_inc;
          end
        end
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase

    // Deselect aborts everything, including a byte that completes in this very clock.
    if (cs_high) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      spi_we  = 1'b0;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      shift_q     <= 8'h00;
      addr_q      <= '0;
      cnt_q       <= 5'd0;
      rd_q        <= 1'b0;
      miso_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      miso_q      <= miso_d;
      err_q       <= err_d;
    end
  end

  // SPI commit is written last so it wins a same-address collision with the backdoor.
  always_ff @(posedge clk_in) begin
    if (bd_we_in) mem[bd_addr_in] <= bd_wdata_in;
    if (spi_we)   mem[addr_q] <= rx_byte;
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: a read/write instance and a read-only instance
// sharing the SPI clock, data and backdoor address lines.
module tb_spi_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1, cs_n_ro = 1'b1;
  logic bd_we = 1'b0, bd_we_ro = 1'b0;
  logic [7:0] bd_addr = 8'h00, bd_wdata = 8'h00;
  logic miso, miso_ro, busy, busy_ro, cmd_err, cmd_err_ro;
  logic [7:0] bd_rdata, bd_rdata_ro;

  int errors = 0;
  int checks = 0;
  int stab_bad = 0;
  bit sel_ro = 1'b0;

  always #5 clk = ~clk;

  spi_mem_responder #(.ADDR_W(8), .WRITE_EN(1'b1)) dut (
    .clk_in(clk), .reset_in(rst), .sclk_in(sclk), .cs_n_in(cs_n), .mosi_in(mosi),
    .miso_out(miso), .bd_we_in(bd_we), .bd_addr_in(bd_addr), .bd_wdata_in(bd_wdata),
    .bd_rdata_out(bd_rdata), .busy_out(busy), .cmd_err_out(cmd_err)
  );

  spi_mem_responder #(.ADDR_W(8), .WRITE_EN(1'b0)) dut_ro (
    .clk_in(clk), .reset_in(rst), .sclk_in(sclk), .cs_n_in(cs_n_ro), .mosi_in(mosi),
    .miso_out(miso_ro), .bd_we_in(bd_we_ro), .bd_addr_in(bd_addr), .bd_wdata_in(bd_wdata),
    .bd_rdata_out(bd_rdata_ro), .busy_out(busy_ro), .cmd_err_out(cmd_err_ro)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bd_write(input logic ro, input logic [7:0] a, input logic [7:0] d);
    bd_addr = a;
    bd_wdata = d;
    if (ro) bd_we_ro = 1'b1; else bd_we = 1'b1;
    wait_clk(1);
    bd_we = 1'b0;
    bd_we_ro = 1'b0;
  endtask

  // One SPI bit: drive mosi in the low phase, sample miso just before the rise,
  // and confirm it has not moved by the middle of the high phase.
  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    wait_clk(6);
    r = sel_ro ? miso_ro : miso;
    sclk = 1'b1;
    wait_clk(3);
    if ((sel_ro ? miso_ro : miso) !== r) stab_bad++;
    wait_clk(3);
    sclk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic cs_begin();
    if (sel_ro) cs_n_ro = 1'b0; else cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_end();
    wait_clk(6);
    cs_n = 1'b1;
    cs_n_ro = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_hdr(input logic [7:0] op, input logic [23:0] a);
    logic [7:0] junk;
    spi_byte(op, junk);
    spi_byte(a[23:16], junk);
    spi_byte(a[15:8], junk);
    spi_byte(a[7:0], junk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
    checks++; if (miso_ro !== 1'b0 || busy_ro !== 1'b0) begin errors++; $display("FAIL reset_ro: got miso=%b busy=%b want 0 0", miso_ro, busy_ro); end
    rst = 1'b0;
    wait_clk(4);
    $display("test_reset done");
  endtask

  task automatic test_read();
    logic [7:0] exp_b [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [7:0] rx;
    for (int i = 0; i < 4; i++) bd_write(1'b0, 8'h10 + 8'(i), exp_b[i]);
    bd_addr = 8'h10; #1;
    checks++; if (bd_rdata !== 8'hA5) begin errors++; $display("FAIL bd_read_10: got %h want a5", bd_rdata); end
    stab_bad = 0;
    cs_begin();
    spi_hdr(8'h03, 24'h000010);
    for (int i = 0; i < 4; i++) begin
      spi_byte(8'h00, rx);
      checks++; if (rx !== exp_b[i]) begin errors++; $display("FAIL read_byte%0d: got %h want %h", i, rx, exp_b[i]); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b want 1", busy); end
    cs_end();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle: got busy=%b want 0", busy); end
    checks++; if (stab_bad != 0) begin errors++; $display("FAIL read_miso_stable: got %0d unstable bits want 0", stab_bad); end
    $display("test_read done");
  endtask

  task automatic test_write();
    logic [7:0] rx;
    logic [7:0] a_tab [4] = '{8'h1F, 8'h20, 8'h21, 8'h22};
    logic [7:0] e_tab [4] = '{8'hEE, 8'h11, 8'h22, 8'hDD};
    bd_write(1'b0, 8'h1F, 8'hEE);
    bd_write(1'b0, 8'h22, 8'hDD);
    cs_begin();
    spi_hdr(8'h02, 24'h000020);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    cs_end();
    for (int i = 0; i < 4; i++) begin
      bd_addr = a_tab[i]; #1;
      checks++; if (bd_rdata !== e_tab[i]) begin errors++; $display("FAIL write_%h: got %h want %h", a_tab[i], bd_rdata, e_tab[i]); end
    end
    $display("test_write done");
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    bd_write(1'b0, 8'hFF, 8'h77);
    bd_write(1'b0, 8'h00, 8'h88);
    cs_begin();
    spi_hdr(8'h03, 24'h0000FF);
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h77) begin errors++; $display("FAIL wrap_read0: got %h want 77", rx); end
    spi_byte(8'h00, rx);
    checks++; if (rx !== 8'h88) begin errors++; $display("FAIL wrap_read1: got %h want 88", rx); end
    cs_end();
    cs_begin();
    spi_hdr(8'h02, 24'hABCDFF);
    spi_byte(8'h5A, rx);
    spi_byte(8'hC3, rx);
    cs_end();
    bd_addr = 8'hFF; #1;
    checks++; if (bd_rdata !== 8'h5A) begin errors++; $display("FAIL wrap_write_ff: got %h want 5a", bd_rdata); end
    bd_addr = 8'h00; #1;
    checks++; if (bd_rdata !== 8'hC3) begin errors++; $display("FAIL wrap_write_00: got %h want c3", bd_rdata); end
    $display("test_wrap done");
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx;
    cs_begin();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 3; i++) begin
      spi_byte(8'hFF, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL badop_miso%0d: got %h want 00", i, rx); end
    end
    spi_byte(8'h00, rx);
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL badop_err: got %b want 1", cmd_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badop_busy: got %b want 0", busy); end
    cs_end();
    checks++; if (cmd_err !== 1'b1) begin errors++; $display("FAIL badop_err_sticky: got %b want 1", cmd_err); end
    bd_addr = 8'hFF; #1;
    checks++; if (bd_rdata !== 8'h5A) begin errors++; $display("FAIL badop_array: got %h want 5a", bd_rdata); end
    $display("test_bad_opcode done");
  endtask

  task automatic test_partial_write();
    logic [7:0] rx;
    logic b;
    bd_write(1'b0, 8'h30, 8'h66);
    cs_begin();
    spi_hdr(8'h02, 24'h000030);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
    cs_end();
    bd_addr = 8'h30; #1;
    checks++; if (bd_rdata !== 8'h66) begin errors++; $display("FAIL partial_array: got %h want 66", bd_rdata); end
    cs_begin();
    spi_hdr(8'h03, 24'h000030);
    spi_byte(8'h00, rx);
    cs_end();
    checks++; if (rx !== 8'h66) begin errors++; $display("FAIL partial_recover: got %h want 66", rx); end
    $display("test_partial_write done");
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    logic b;
    cs_begin();
    spi_hdr(8'h03, 24'h000012);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b);
    wait_clk(5);
    checks++; if (miso !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midread_pre: got miso=%b busy=%b want 1 1", miso, busy); end
    rst = 1'b1;
    #1;
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL midread_miso: got %b want 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midread_busy: got %b want 0", busy); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL midread_err: got %b want 0", cmd_err); end
    wait_clk(2);
    cs_n = 1'b1;
    wait_clk(8);
    rst = 1'b0;
    wait_clk(8);
    cs_begin();
    spi_hdr(8'h03, 24'h000010);
    spi_byte(8'h00, rx);
    cs_end();
    checks++; if (rx !== 8'hA5) begin errors++; $display("FAIL midread_recover: got %h want a5", rx); end
    $display("test_reset_mid_read done");
  endtask

  task automatic test_read_only();
    logic [7:0] rx;
    bd_write(1'b1, 8'h40, 8'h5A);
    sel_ro = 1'b1;
    cs_begin();
    spi_hdr(8'h02, 24'h000040);
    spi_byte(8'h11, rx);
    cs_end();
    bd_addr = 8'h40; #1;
    checks++; if (bd_rdata_ro !== 8'h5A) begin errors++; $display("FAIL ro_array: got %h want 5a", bd_rdata_ro); end
    checks++; if (cmd_err_ro !== 1'b0) begin errors++; $display("FAIL ro_err: got %b want 0", cmd_err_ro); end
    cs_begin();
    spi_hdr(8'h03, 24'h000040);
    spi_byte(8'h00, rx);
    cs_end();
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL ro_read: got %h want 5a", rx); end
    sel_ro = 1'b0;
    $display("test_read_only done");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_bad_opcode();
    test_partial_write();
    test_reset_mid_read();
    test_read_only();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
